// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte buffer placed directly behind a UART receiver.
//  - Captures one byte per rising edge of the receiver's done strobe,
//    independent of how long the strobe stays high.
//  - Stores bytes in a circular buffer and presents the oldest entry
//    first-word-fall-through: rd_data_o is the head whenever empty_o=0.
//  - Drops a byte that arrives while the buffer is full (and nothing is
//    popped in that cycle), and raises a sticky overrun flag.
//
// Optional feature macro: UART_RX_FIFO_LEVEL_EN
//  When defined, adds level_o (entry count) and almost_full_o
//  (count >= AF_LEVEL). When undefined those ports do not exist and
//  AF_LEVEL has no effect on the logic.
//
// Parameters
//  DATA_W      byte width, must match the receiver
//  DEPTH_LOG2  log2 of the entry count (1..8)
//  AF_LEVEL    almost-full threshold in entries (macro build only)
//
// Ports
//  clk_i          system clock
//  rst_i          asynchronous active-high reset
//  rx_data_i      received byte
//  rx_done_i      receiver done strobe (level, one or more cycles)
//  rd_en_i        consumer pop request (ignored while empty)
//  clr_overrun_i  clears the sticky overrun flag
//  rd_data_o      head entry, valid while empty_o=0
//  empty_o        buffer holds no entries
//  full_o         buffer holds 2**DEPTH_LOG2 entries
//  overrun_o      sticky, at least one byte has been dropped
//  level_o        entry count (macro build only)
//  almost_full_o  level_o >= AF_LEVEL (macro build only)
//------------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4,
   parameter int AF_LEVEL   = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_W-1:0]     rx_data_i,
   input  logic                  rx_done_i,
   input  logic                  rd_en_i,
   input  logic                  clr_overrun_i,
   output logic [DATA_W-1:0]     rd_data_o,
   output logic                  empty_o,
   output logic                  full_o,
`ifdef UART_RX_FIFO_LEVEL_EN
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  almost_full_o,
`endif
   output logic                  overrun_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;

   // Elaboration-time guard against unsupported configurations.
   if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8 || AF_LEVEL < 0) begin : g_bad_cfg
      $error("uart_rx_fifo: DEPTH_LOG2 must be 1..8 and AF_LEVEL non-negative");
   end

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   logic                  rx_done_q;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q,  count_d;
   logic                  overrun_q, overrun_d;
   logic [DATA_W-1:0]     mem_q [DEPTH];

   //---------------------------------------------------------------------------
   // Control
   //---------------------------------------------------------------------------
   logic push;      // rising edge of the done strobe
   logic pop;       // accepted read
   logic wr_accept; // push that actually lands in storage
   logic drop;      // push lost because the buffer is full

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));

   assign push = rx_done_i & ~rx_done_q;
   assign pop  = rd_en_i & ~empty_o;

   // When full, a simultaneous pop frees the head slot in the same cycle,
   // so the incoming byte can take it. Since wr_ptr == rd_ptr when full,
   // the write lands on the slot being popped; the combinational read
   // still returns the old head during this cycle.
   assign wr_accept = push & (~full_o | pop);
   assign drop      = push & full_o & ~pop;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      // Push and pop together leave the count unchanged. Empty blocks pop
      // and full blocks a lone push, so the count stays within 0..DEPTH.
      unique case ({wr_accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Set has priority over clear so a drop is never lost.
      if (drop) begin
         overrun_d = 1'b1;
      end else if (clr_overrun_i) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_done_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         rx_done_q <= rx_done_i;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage is deliberately not reset; empty_o guards any stale contents.
   always_ff @(posedge clk_i) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q] <= rx_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign overrun_o = overrun_q;

`ifdef UART_RX_FIFO_LEVEL_EN
   assign level_o       = count_q;
   assign almost_full_o = (count_q >= CNT_W'(AF_LEVEL));
`endif

endmodule
